inst_fifo: RTL

INST_FIFO -- requirements
Module: inst_fifo

---
 rtl/inst_fifo_if.sv | 29 ++
 rtl/inst_fifo.sv | 95 +++++++++
 2 files changed

// File: rtl/inst_fifo_if.sv
// Fetch-to-decode instruction queue bus: push side from fetch, head side to decode.
interface inst_fifo_if #(
  parameter int DEPTH = 4
);
  logic                     push_valid;
  logic                     push_ready;
  logic [31:0]              push_instr;
  logic [31:0]              push_pc;
  logic                     push_adel;
  logic                     pop;
  logic                     flush;
  logic                     validD;
  logic [31:0]              instrD;
  logic [31:0]              pcD;
  logic                     adelD;
  logic [$clog2(DEPTH):0]   count;

  // Fetch/decode side driving the queue
  modport master (
    output push_valid, push_instr, push_pc, push_adel, pop, flush,
    input  push_ready, validD, instrD, pcD, adelD, count
  );

  // Queue itself
  modport slave (
    input  push_valid, push_instr, push_pc, push_adel, pop, flush,
    output push_ready, validD, instrD, pcD, adelD, count
  );
endinterface

// File: rtl/inst_fifo.sv
// Instruction queue between fetch and decode: circular buffer of {adel, pc, instr}
// with one-cycle first-word latency, synchronous flush and a NOP-filled empty head.
module inst_fifo #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         resetn,
  inst_fifo_if.slave   bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [64:0]   mem_r [DEPTH];
  logic [AW-1:0] rdPtr_r;
  logic [AW-1:0] wrPtr_r;
  logic [CW-1:0] count_r;

  logic          pushAcc_s;
  logic          popAcc_s;
  logic [CW-1:0] countNext_s;
  logic [AW-1:0] rdPtrNext_s;
  logic [AW-1:0] wrPtrNext_s;
  logic [64:0]   head_s;

  // push_ready and validD derive only from the registered count, so pop never
  // reaches push_ready combinationally; flush cancels both handshakes.
  assign pushAcc_s = bus.push_valid & (count_r < FULL_CNT) & ~bus.flush;
  assign popAcc_s  = bus.pop & (count_r != {CW{1'b0}}) & ~bus.flush;

  // Next pointer and occupancy values for accepted transfers
  always_comb begin
    rdPtrNext_s = rdPtr_r;
    wrPtrNext_s = wrPtr_r;
    countNext_s = count_r;
    if (popAcc_s) begin
      rdPtrNext_s = (rdPtr_r == LAST_PTR) ? {AW{1'b0}} : rdPtr_r + AW'(1);
    end else begin
      rdPtrNext_s = rdPtr_r;
    end
    if (pushAcc_s) begin
      wrPtrNext_s = (wrPtr_r == LAST_PTR) ? {AW{1'b0}} : wrPtr_r + AW'(1);
    end else begin
      wrPtrNext_s = wrPtr_r;
    end
    case ({pushAcc_s, popAcc_s})
      2'b10:   countNext_s = count_r + CW'(1);
      2'b01:   countNext_s = count_r - CW'(1);
      default: countNext_s = count_r;
    endcase
  end

  // Pointer and occupancy registers; flush clears them, entries are kept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdPtr_r <= {AW{1'b0}};
      wrPtr_r <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (bus.flush) begin
      rdPtr_r <= {AW{1'b0}};
      wrPtr_r <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      rdPtr_r <= rdPtrNext_s;
      wrPtr_r <= wrPtrNext_s;
      count_r <= countNext_s;
    end
  end

  // Entry storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (pushAcc_s) begin
      mem_r[wrPtr_r] <= {bus.push_adel, bus.push_pc, bus.push_instr};
    end
  end

  // Head entry, replaced by an all-zero NOP whenever the queue is empty
  always_comb begin
    head_s = 65'h0;
    if (count_r != {CW{1'b0}}) begin
      head_s = mem_r[rdPtr_r];
    end else begin
      head_s = 65'h0;
    end
  end

  assign bus.push_ready = (count_r < FULL_CNT);
  assign bus.validD     = (count_r != {CW{1'b0}});
  assign bus.instrD     = head_s[31:0];
  assign bus.pcD        = head_s[63:32];
  assign bus.adelD      = head_s[64];
  assign bus.count      = count_r;

endmodule
